// File: rtl/peripheral_comunicaciones_rx.sv
// rtl/peripheral_comunicaciones_rx.sv - J1 I/O peripheral: 8N1 UART receiver, byte FIFO and "OK\r\n" detector
module peripheral_comunicaciones_rx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_AW      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    input  logic        rx,
    output logic        rx_ready,
    output logic        ok_flag
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]    HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]    FULL_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] DEPTH_CT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
    } rx_state_t;

    rx_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               rx_meta_q, rx_s_q;
    logic               push_req, ferr_set;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               overrun_q, frame_err_q, ok_seen_q;
    logic [1:0]         match_q;

    logic               empty, full;
    logic               bus_rd, pop_req, ctrl_wr, flush;
    logic               do_pop, do_push, ov_set, ok_set;
    logic [7:0]         match_char;
    logic [15:0]        status;
    logic               unused_d_in;

    assign unused_d_in = ^d_in[15:4];

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receiver state, bit-timing counter and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Receiver next state: mid-start-bit check, then one sample per bit time
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus decode and FIFO arbitration: flush beats everything, a pop frees room for a same-cycle push
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == DEPTH_CT);
        bus_rd  = cs && rd;
        pop_req = bus_rd && (addr == 4'h0) && !empty;
        ctrl_wr = cs && wr && (addr == 4'h4);
        flush   = ctrl_wr && d_in[3];
        do_pop  = pop_req && !flush;
        do_push = push_req && !flush && (!full || pop_req);
        ov_set  = push_req && !flush && full && !pop_req;
        case (match_q)
            2'd0:    match_char = 8'h4F;
            2'd1:    match_char = 8'h4B;
            2'd2:    match_char = 8'h0D;
            default: match_char = 8'h0A;
        endcase
        ok_set = push_req && (match_q == 2'd3) && (shift_q == match_char);
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Sticky flags: a set in the same cycle as its clear wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ok_seen_q   <= 1'b0;
        end else begin
            overrun_q   <= (overrun_q   && !(ctrl_wr && d_in[0])) || ov_set;
            frame_err_q <= (frame_err_q && !(ctrl_wr && d_in[1])) || ferr_set;
            ok_seen_q   <= (ok_seen_q   && !(ctrl_wr && d_in[2])) || ok_set;
        end
    end

    // "OK\r\n" matcher; sees every well-framed byte, even ones the full FIFO drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 2'd0;
        end else if (ferr_set) begin
            match_q <= 2'd0;
        end else if (push_req) begin
            if (shift_q == match_char) begin
                match_q <= (match_q == 2'd3) ? 2'd0 : match_q + 1'b1;
            end else begin
                match_q <= (shift_q == 8'h4F) ? 2'd1 : 2'd0;
            end
        end
    end

    // Read mux: DATA shows the FIFO head, STATUS packs flags and count
    always_comb begin
        status                 = '0;
        status[0]              = !empty;
        status[1]              = full;
        status[2]              = overrun_q;
        status[3]              = frame_err_q;
        status[4]              = ok_seen_q;
        status[5]              = (state_q != S_IDLE);
        status[8+FIFO_AW:8]    = count_q;
        d_out = '0;
        if (bus_rd) begin
            case (addr)
                4'h0:    d_out = empty ? 16'h0000 : {8'h00, mem_q[rd_ptr_q]};
                4'h2:    d_out = status;
                default: d_out = '0;
            endcase
        end
    end

    assign rx_ready = !empty;
    assign ok_flag  = ok_seen_q;

endmodule

// File: tb/tb_peripheral_comunicaciones_rx.sv
// tb/tb_peripheral_comunicaciones_rx.sv - scoreboard bench for the UART receive peripheral
module tb_peripheral_comunicaciones_rx;

    localparam int CPB   = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic        cs, rd, wr, rx;
    logic [3:0]  addr;
    logic [15:0] d_out;
    logic        rx_ready, ok_flag;

    peripheral_comunicaciones_rx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_out(d_out), .rx(rx), .rx_ready(rx_ready), .ok_flag(ok_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    byte unsigned m_fifo[$];
    byte unsigned hist[$];
    bit          m_ov, m_fe, m_ok;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Monitor: every bus read is matched against the oldest queued expectation
    always @(negedge clk) begin
        if (cs === 1'b1 && rd === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read: got 0x%04h expected nothing queued", d_out);
            end else begin
                check(tag_q.pop_front(), d_out, exp_q.pop_front());
            end
        end
    end

    function automatic logic [15:0] status_exp();
        logic [15:0] s;
        s       = '0;
        s[0]    = (m_fifo.size() != 0);
        s[1]    = (m_fifo.size() == DEPTH);
        s[2]    = m_ov;
        s[3]    = m_fe;
        s[4]    = m_ok;
        s[12:8] = 5'(m_fifo.size());
        return s;
    endfunction

    function automatic logic [15:0] read_exp(input logic [3:0] a);
        if (a == 4'h0) return (m_fifo.size() != 0) ? {8'h00, m_fifo[0]} : 16'h0000;
        if (a == 4'h2) return status_exp();
        return 16'h0000;
    endfunction

    task automatic do_read(input logic [3:0] a, input string tag, input logic [15:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(posedge clk); #1;
        cs = 1'b0; rd = 1'b0;
        if (a == 4'h0 && m_fifo.size() != 0) void'(m_fifo.pop_front());
    endtask

    task automatic bus_read(input logic [3:0] a, input string tag);
        do_read(a, tag, read_exp(a));
    endtask

    task automatic bus_read_lit(input logic [3:0] a, input string tag, input logic [15:0] e);
        do_read(a, tag, e);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(posedge clk); #1;
        cs = 1'b0; wr = 1'b0;
        if (a == 4'h4) begin
            if (d[0]) m_ov = 1'b0;
            if (d[1]) m_fe = 1'b0;
            if (d[2]) m_ok = 1'b0;
            if (d[3]) m_fifo.delete();
        end
    endtask

    task automatic model_accept(input byte unsigned b);
        hist.push_back(b);
        if (hist.size() > 4) void'(hist.pop_front());
        if (hist.size() == 4 && hist[0] == 8'h4F && hist[1] == 8'h4B &&
            hist[2] == 8'h0D && hist[3] == 8'h0A) m_ok = 1'b1;
        if (m_fifo.size() == DEPTH) m_ov = 1'b1;
        else m_fifo.push_back(b);
    endtask

    task automatic model_reset();
        m_fifo.delete();
        hist.delete();
        m_ov = 1'b0; m_fe = 1'b0; m_ok = 1'b0;
    endtask

    task automatic wait_bit();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low);
        @(posedge clk); #1;
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bit();
        end
        rx = stop_ok;
        wait_bit();
        if (!stop_ok) repeat (extra_low) wait_bit();
        rx = 1'b1;
        wait_bit();
        if (stop_ok) model_accept(b);
        else begin
            m_fe = 1'b1;
            hist.delete();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ok_str [6];
        logic [7:0] b;
        int op;
        ok_str[0] = 8'h78; ok_str[1] = 8'h4F; ok_str[2] = 8'h4F;
        ok_str[3] = 8'h4B; ok_str[4] = 8'h0D; ok_str[5] = 8'h0A;

        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0; rx = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("reset_rx_ready", {15'd0, rx_ready}, 16'h0000);
        check("reset_ok_flag", {15'd0, ok_flag}, 16'h0000);
        bus_read_lit(4'h2, "reset_status", 16'h0000);

        // Single byte
        send_frame(8'h55, 1'b1, 0);
        check("rx_ready_55", {15'd0, rx_ready}, 16'h0001);
        bus_read_lit(4'h2, "status_55", 16'h0101);
        bus_read_lit(4'h0, "data_55", 16'h0055);
        bus_read_lit(4'h2, "status_after_55", 16'h0000);
        bus_read_lit(4'h0, "data_empty", 16'h0000);

        // Overflow: 17 bytes with no reads
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 0);
        bus_read_lit(4'h2, "status_full_ovr", 16'h1007);
        for (int i = 0; i < 16; i++) bus_read_lit(4'h0, $sformatf("data_order_%0d", i), 16'(i));
        bus_read_lit(4'h2, "status_drained_ovr", 16'h0004);
        bus_write(4'h4, 16'h0001);
        bus_read_lit(4'h2, "status_ovr_clr", 16'h0000);

        // Framing error followed by a long break
        send_frame(8'hA5, 1'b0, 3);
        bus_read_lit(4'h2, "status_ferr", 16'h0008);
        bus_write(4'h4, 16'h0002);
        bus_read_lit(4'h2, "status_ferr_clr", 16'h0000);

        // Start-bit glitch
        @(posedge clk); #1 rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus_read_lit(4'h2, "status_glitch_busy", 16'h0020);
        repeat (4) @(posedge clk);
        #1;
        bus_read_lit(4'h2, "status_glitch_idle", 16'h0000);

        // OK detection
        for (int i = 0; i < 5; i++) send_frame(ok_str[i], 1'b1, 0);
        check("ok_flag_before_lf", {15'd0, ok_flag}, 16'h0000);
        send_frame(ok_str[5], 1'b1, 0);
        check("ok_flag_after_lf", {15'd0, ok_flag}, 16'h0001);
        bus_read_lit(4'h2, "status_ok", 16'h0611);
        bus_write(4'h4, 16'h0004);
        check("ok_flag_clr", {15'd0, ok_flag}, 16'h0000);
        bus_write(4'h4, 16'h0008);
        bus_read_lit(4'h2, "status_flushed", 16'h0000);

        // Reset in the middle of data bit 3
        send_frame(8'h11, 1'b1, 0);
        @(posedge clk); #1 rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            wait_bit();
        end
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; rx = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check("rst_mid_rx_ready", {15'd0, rx_ready}, 16'h0000);
        bus_read_lit(4'h2, "status_rst_mid", 16'h0000);
        repeat (2) wait_bit();
        send_frame(8'h3C, 1'b1, 0);
        bus_read_lit(4'h0, "data_3c", 16'h003C);

        // Full FIFO: pop on the same cycle as the push of byte 17
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b1, 0);
        bus_read(4'h2, "status_full");
        b = 8'($urandom_range(0, 255));
        fork
            send_frame(b, 1'b1, 0);
            begin
                @(posedge clk);
                repeat (78) @(posedge clk);
                #1;
                bus_read(4'h0, "data_pop_on_push");
            end
        join
        bus_read_lit(4'h2, "status_pop_push", status_exp() & 16'h1F04 | 16'h1003);
        bus_read(4'h2, "status_pop_push_model");
        for (int i = 0; i < DEPTH; i++) bus_read(4'h0, $sformatf("data_after_pp_%0d", i));

        // Randomised traffic against the model
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                case ($urandom_range(0, 5))
                    0: b = 8'h4F;
                    1: b = 8'h4B;
                    2: b = 8'h0D;
                    3: b = 8'h0A;
                    default: b = 8'($urandom_range(0, 255));
                endcase
                send_frame(b, $urandom_range(0, 7) != 0, $urandom_range(0, 2));
            end else if (op <= 6) begin
                bus_read(4'h0, "rand_data");
            end else if (op == 7) begin
                bus_read(4'h2, "rand_status");
            end else if (op == 8) begin
                bus_write(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h4,
                          16'($urandom_range(0, 15)));
            end else begin
                bus_read(4'($urandom_range(0, 15)), "rand_addr");
            end
            check("rand_ok_flag", {15'd0, ok_flag}, {15'd0, m_ok});
        end
        bus_read(4'h2, "final_status");
        while (m_fifo.size() != 0) bus_read(4'h0, "final_drain");
        bus_read_lit(4'h2, "final_empty", {11'd0, m_ok, m_fe, m_ov, 2'b00});

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
